// File: rtl/ps2_host_tx_if.sv
// Command handshake between a PS/2 host transmitter and its requester.
// The requester drives the byte and start pulse; the transmitter reports status.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       timeout;
  logic       rx_inhibit;

  modport master (
    output tx_data, tx_start,
    input  busy, done, ack_ok, timeout, rx_inhibit
  );

  modport slave (
    input  tx_data, tx_start,
    output busy, done, ack_ok, timeout, rx_inhibit
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 11 device-clocked
// bit slots (8 data, odd parity, stop, ACK) with a watchdog on device clock activity.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES   = 960,
  parameter int DATA_LEAD_CYCLES = 16,
  parameter int FILTER_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES   = 120000
) (
  input  logic         clk,
  input  logic         res,
  ps2_host_tx_if.slave host,
  input  logic         ps2clk_in,
  input  logic         ps2data_in,
  output logic         ps2clk_oe,
  output logic         ps2data_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam int FW = $clog2(FILTER_CYCLES + 1);

  localparam logic [IW-1:0] INH_LAST   = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] LEAD_START = IW'(INHIBIT_CYCLES - DATA_LEAD_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] F_LAST     = FW'(FILTER_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_SHIFT     = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;
  localparam logic [2:0] S_TOUT      = 3'd6;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // index 0 = clock line, index 1 = data line
  logic [1:0]    sync1_q, sync2_q, filt_q;
  logic [FW-1:0] fcnt_q [2];
  logic          clk_prev_q;
  logic          fall_s;

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    shift_q, shift_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ack_ok_q, ack_ok_d;
  logic          timeout_q, timeout_d;
  logic          ack_seen_q, ack_seen_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          wd_active_s, wd_expire_s;

  // Synchronize both pins and only follow a level after FILTER_CYCLES stable samples.
  always_ff @(posedge clk) begin
    if (res) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      clk_prev_q <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        fcnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= {ps2data_in, ps2clk_in};
      sync2_q    <= sync1_q;
      clk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == F_LAST) begin
          fcnt_q[i] <= '0;
          filt_q[i] <= sync2_q[i];
        end else begin
          fcnt_q[i] <= fcnt_q[i] + FW'(1);
        end
      end
    end
  end

  assign fall_s      = clk_prev_q & ~filt_q[0];
  assign wd_active_s = (state_q == S_REQ) || (state_q == S_SHIFT) ||
                       (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
  assign wd_expire_s = wd_active_s && !fall_s && (wd_q == WD_LAST);

  // Transfer sequencing, line drive and watchdog next-state.
  always_comb begin
    state_d    = state_q;
    inh_d      = inh_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ack_ok_d   = ack_ok_q;
    timeout_d  = timeout_q;
    ack_seen_d = ack_seen_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;

    if (wd_active_s) begin
      if (fall_s) begin
        wd_d = '0;
      end else begin
        wd_d = wd_q + WW'(1);
      end
    end else begin
      wd_d = '0;
    end

    if (wd_expire_s) begin
      // release first; the done pulse follows one cycle later from S_TOUT
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      state_d   = S_TOUT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (host.tx_start && !done_q) begin
            state_d    = S_INHIBIT;
            busy_d     = 1'b1;
            ack_ok_d   = 1'b0;
            timeout_d  = 1'b0;
            ack_seen_d = 1'b0;
            shift_d    = {1'b1, odd_parity(host.tx_data), host.tx_data};
            inh_d      = '0;
            bit_d      = 4'd0;
            clk_oe_d   = 1'b1;
            data_oe_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_INHIBIT: begin
          inh_d = inh_q + IW'(1);
          if (inh_q == INH_LAST) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b1;
            state_d   = S_REQ;
          end else if (inh_q == LEAD_START) begin
            data_oe_d = 1'b1;
          end else begin
            data_oe_d = data_oe_q;
          end
        end
        S_REQ: begin
          if (fall_s) begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b1, shift_q[9:1]};
            bit_d     = 4'd1;
            state_d   = S_SHIFT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_SHIFT: begin
          // bit_q counts slots already placed; the 10th placement is the stop bit
          if (fall_s) begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b1, shift_q[9:1]};
            bit_d     = bit_q + 4'd1;
            state_d   = (bit_q == 4'd9) ? S_ACK : S_SHIFT;
          end else begin
            state_d = S_SHIFT;
          end
        end
        S_ACK: begin
          if (fall_s) begin
            ack_seen_d = ~filt_q[1];
            state_d    = S_WAIT_IDLE;
          end else begin
            state_d = S_ACK;
          end
        end
        S_WAIT_IDLE: begin
          if (filt_q == 2'b11) begin
            done_d   = 1'b1;
            busy_d   = 1'b0;
            ack_ok_d = ack_seen_q;
            state_d  = S_IDLE;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end
        S_TOUT: begin
          done_d    = 1'b1;
          timeout_d = 1'b1;
          ack_ok_d  = 1'b0;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
        default: begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; reset releases both lines without a done pulse.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= S_IDLE;
      inh_q      <= '0;
      wd_q       <= '0;
      bit_q      <= 4'd0;
      shift_q    <= 10'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_ok_q   <= 1'b0;
      timeout_q  <= 1'b0;
      ack_seen_q <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inh_q      <= inh_d;
      wd_q       <= wd_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_ok_q   <= ack_ok_d;
      timeout_q  <= timeout_d;
      ack_seen_q <= ack_seen_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
    end
  end

  assign ps2clk_oe       = clk_oe_q;
  assign ps2data_oe      = data_oe_q;
  assign host.busy       = busy_q;
  assign host.rx_inhibit = busy_q;
  assign host.done       = done_q;
  assign host.ack_ok     = ack_ok_q;
  assign host.timeout    = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, a PS/2 device model that records the
// frame it clocks in, and a per-cycle checker built from the transfer rules.
module tb_ps2_host_tx;

  localparam int INH  = 960;
  localparam int LEAD = 16;
  localparam int TOUT = 3000;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2clk_oe, ps2data_oe;
  logic ps2clk_line, ps2data_line;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_host_tx_if host_if ();

  assign ps2clk_line  = ~(ps2clk_oe | dev_clk_low);
  assign ps2data_line = ~(ps2data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES  (INH),
    .DATA_LEAD_CYCLES(LEAD),
    .FILTER_CYCLES   (8),
    .TIMEOUT_CYCLES  (TOUT)
  ) dut (
    .clk       (clk),
    .res       (res),
    .host      (host_if),
    .ps2clk_in (ps2clk_line),
    .ps2data_in(ps2data_line),
    .ps2clk_oe (ps2clk_oe),
    .ps2data_oe(ps2data_oe)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected behaviour per transfer, set by the stimulus before each request.
  bit exp_ack = 1'b0;
  bit exp_to  = 1'b0;
  bit to_mode = 1'b0;

  // Per-cycle model state.
  int m_t      = 0;
  bit exp_busy = 1'b0;
  bit hold_ack = 1'b0;
  bit hold_to  = 1'b0;
  bit busy_p   = 1'b0;
  bit done_p   = 1'b0;

  always @(posedge clk) begin
    #1;
    if (res) begin
      exp_busy = 1'b0;
      m_t      = 0;
      hold_ack = 1'b0;
      hold_to  = 1'b0;
      chk("reset_busy", host_if.busy, 0);
      chk("reset_done", host_if.done, 0);
      chk("reset_clk_oe", ps2clk_oe, 0);
      chk("reset_data_oe", ps2data_oe, 0);
      chk("reset_ack_ok", host_if.ack_ok, 0);
      chk("reset_timeout", host_if.timeout, 0);
    end else begin
      if (host_if.tx_start && !busy_p && !done_p) begin
        exp_busy = 1'b1;
        m_t      = 0;
        hold_ack = 1'b0;
        hold_to  = 1'b0;
      end
      if (exp_busy) m_t++;
      if (host_if.done) begin
        chk("done_while_busy", 1, exp_busy);
        chk("done_ack_ok", host_if.ack_ok, exp_ack);
        chk("done_timeout", host_if.timeout, exp_to);
        if (to_mode) chk("timeout_done_cycle", m_t, INH + TOUT + 2);
        exp_busy = 1'b0;
        hold_ack = exp_ack;
        hold_to  = exp_to;
      end
      chk("busy", host_if.busy, exp_busy);
      chk("rx_inhibit", host_if.rx_inhibit, host_if.busy);
      chk("ack_ok_hold", host_if.ack_ok, hold_ack);
      chk("timeout_hold", host_if.timeout, hold_to);
      if (exp_busy) begin
        if (m_t <= INH) begin
          chk("inhibit_clk_oe", ps2clk_oe, 1);
          chk("inhibit_data_oe", ps2data_oe, (m_t > INH - LEAD) ? 1 : 0);
        end else begin
          chk("post_inhibit_clk_oe", ps2clk_oe, 0);
        end
        if (to_mode && m_t > INH && m_t <= INH + TOUT) chk("req_data_oe", ps2data_oe, 1);
        if (to_mode && m_t == INH + TOUT + 1) chk("timeout_release", ps2data_oe, 0);
      end else begin
        chk("idle_clk_oe", ps2clk_oe, 0);
        chk("idle_data_oe", ps2data_oe, 0);
      end
    end
    busy_p = host_if.busy;
    done_p = host_if.done;
  end

  task automatic send(input logic [7:0] d, input bit ack, input bit to);
    exp_ack = ack & ~to;
    exp_to  = to;
    to_mode = to;
    @(negedge clk);
    host_if.tx_data  = d;
    host_if.tx_start = 1'b1;
    @(negedge clk);
    host_if.tx_start = 1'b0;
  endtask

  // Device side: watch the inhibit, then clock nfalls bit slots, sampling while clock is high.
  task automatic device(input int h, input int nfalls, input bit ack, input int glitch_after,
                        output logic [9:0] rx, output int inh_len, output int lead_len);
    int n = 0;
    rx = 10'd0;
    inh_len = 0;
    lead_len = 0;
    while (!ps2clk_oe && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("dev_inhibit_seen", ps2clk_oe, 1);
    if (ps2clk_oe) begin
      while (ps2clk_oe && inh_len < 3000) begin
        inh_len++;
        if (ps2data_oe) lead_len++;
        @(negedge clk);
      end
      chk("dev_start_bit", ps2data_oe, 1);
      repeat (h) @(negedge clk);
      for (int k = 0; k < nfalls; k++) begin
        if (k == 10) begin
          dev_data_low = ack;
          repeat (h / 2) @(negedge clk);
        end
        dev_clk_low = 1'b1;
        repeat (h) @(negedge clk);
        dev_clk_low = 1'b0;
        if (k == 10) dev_data_low = 1'b0;
        repeat (h / 2) @(negedge clk);
        if (k < 10) rx[k] = ps2data_line;
        if (k == glitch_after) begin
          dev_clk_low = 1'b1;
          repeat (3) @(negedge clk);
          dev_clk_low = 1'b0;
        end
        repeat (h / 2) @(negedge clk);
      end
    end
  endtask

  task automatic wait_done(input int budget, input bit poke);
    int n = 0;
    while (host_if.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", host_if.done, 1);
    if (poke && host_if.done) begin
      host_if.tx_data  = 8'hFF;
      host_if.tx_start = 1'b1;
      @(negedge clk);
      host_if.tx_start = 1'b0;
      repeat (3) @(negedge clk);
      chk("start_in_done_ignored", host_if.busy, 0);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic full_xfer(input logic [7:0] d, input int h, input bit ack, input int glitch,
                           input bit poke, input logic [9:0] exp_frame, input string nm);
    logic [9:0] rx;
    int inh_len, lead_len;
    send(d, ack, 1'b0);
    fork
      device(h, 11, ack, glitch, rx, inh_len, lead_len);
      wait_done(40 * h + 3000, poke);
    join
    chk(nm, rx, exp_frame);
    chk("inhibit_len", inh_len, INH);
    chk("data_lead_len", lead_len, LEAD);
    chk("busy_after_done", host_if.busy, 0);
  endtask

  initial begin
    logic [9:0] rx;
    int inh_len, lead_len;
    host_if.tx_data  = 8'h00;
    host_if.tx_start = 1'b0;
    repeat (5) @(negedge clk);
    res = 1'b0;
    repeat (5) @(negedge clk);

    // 0xF4 at 12.5 kHz: bits 0,0,1,0,1,1,1,1, parity 0, stop 1; start poked in done cycle
    full_xfer(8'hF4, 320, 1'b1, -1, 1'b1, 10'h2F4, "frame_F4");

    // 0xFF with an ignored request while busy; 0x00; both carry parity 1
    send(8'hFF, 1'b1, 1'b0);
    fork
      device(100, 11, 1'b1, -1, rx, inh_len, lead_len);
      wait_done(7000, 1'b0);
      begin
        repeat (500) @(negedge clk);
        host_if.tx_data  = 8'h00;
        host_if.tx_start = 1'b1;
        @(negedge clk);
        host_if.tx_start = 1'b0;
      end
    join
    chk("frame_FF", rx, 10'h3FF);
    full_xfer(8'h00, 100, 1'b1, -1, 1'b0, 10'h300, "frame_00");

    // no ACK from the device on 0xED
    full_xfer(8'hED, 100, 1'b0, -1, 1'b0, 10'h3ED, "frame_ED");

    // device silent after the request
    send(8'hA5, 1'b0, 1'b1);
    wait_done(INH + TOUT + 500, 1'b0);
    to_mode = 1'b0;
    full_xfer(8'hF4, 100, 1'b1, -1, 1'b0, 10'h2F4, "frame_F4_after_timeout");

    // reset after the 4th data bit, then an immediate fresh request
    send(8'hF4, 1'b1, 1'b0);
    device(100, 4, 1'b1, -1, rx, inh_len, lead_len);
    chk("partial_bits", rx[3:0], 4'h4);
    chk("partial_data_oe_driven", ps2data_oe, 1);
    @(negedge clk);
    res = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_reset_clk_oe", ps2clk_oe, 0);
    chk("mid_reset_data_oe", ps2data_oe, 0);
    chk("mid_reset_busy", host_if.busy, 0);
    @(negedge clk);
    res = 1'b0;
    exp_ack = 1'b1;
    exp_to  = 1'b0;
    host_if.tx_data  = 8'hF4;
    host_if.tx_start = 1'b1;
    fork
      device(100, 11, 1'b1, -1, rx, inh_len, lead_len);
      begin
        @(negedge clk);
        host_if.tx_start = 1'b0;
        chk("fresh_accept_busy", host_if.busy, 1);
        wait_done(7000, 1'b0);
      end
    join
    chk("frame_F4_after_reset", rx, 10'h2F4);

    // 3-cycle clock glitch during the data bits must not advance the shifter
    full_xfer(8'h01, 100, 1'b1, 2, 1'b0, 10'h201, "frame_01_glitch");

    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL global_time_limit: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
